// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state type and default sizing.
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNT_W = 5;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit. One radix-2 step per cycle over a
// shared shift datapath, then a single sign fix-up / writeback cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; MTHI/MTLO complete here in one cycle
//   S_CALC | WIDTH shift-add (mult) or restoring-subtract (div) steps
//   S_FIX  | apply sign fix-up, write HI/LO, raise done for one cycle
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is exactly its magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  mdu_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic               r_sa, r_sb;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;

  logic               w_start_md;
  logic               w_signed_op;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic               w_neg_q;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic               w_div0;

  assign w_start_md  = start && !op[2];
  assign w_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign w_neg_a     = w_signed_op && rs_data[WIDTH-1];
  assign w_neg_b     = w_signed_op && rt_data[WIDTH-1];
  assign w_mag_a     = f_mag(rs_data, w_neg_a);
  assign w_mag_b     = f_mag(rt_data, w_neg_b);

  // Multiply step: add multiplicand into the upper half, keep the carry,
  // shift the whole accumulator right by one.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  // Divide step: remainder is the low WIDTH bits; the shifted value needs one
  // extra bit. When it fits, the true difference is below 2^WIDTH, so a
  // WIDTH-bit subtract is exact.
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  // Sign fix-up; sign flags are only ever set for the signed ops.
  assign w_neg_q = r_sa ^ r_sb;
  assign w_prod  = w_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quo   = w_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem   = r_sa ? (~r_rem + 1'b1) : r_rem;
  assign w_div0  = (r_b == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush only matters once an op is in flight.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_start_md) w_state_nxt = S_CALC;
      S_CALC: begin
        if (flush)                                w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1))      w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_div  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_rem  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start_md) begin
            r_cnt <= '0;
            r_div <= op[1];
            r_sa  <= w_neg_a;
            r_sb  <= w_neg_b;
            r_a   <= w_mag_a;
            r_b   <= w_mag_b;
            r_rem <= '0;
            r_acc <= op[1] ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
          end else if (start && op == MDU_MTHI) begin
            r_hi <= rs_data;
          end else if (start && op == MDU_MTLO) begin
            r_lo <= rs_data;
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_div) begin
              r_rem              <= w_ge ? w_diff : w_shift[WIDTH-1:0];
              r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
            end else begin
              r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_done <= 1'b1;
            if (r_div) begin
              r_hi <= w_rem;
              r_lo <= w_div0 ? {WIDTH{1'b1}} : w_quo;
            end else begin
              {r_hi, r_lo} <= w_prod;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected {hi,lo} pairs are queued at
// issue time and popped when done pulses.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, independent of the iterative datapath.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv, pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'b000: begin pv = 64'(sa * sb); return pv; end
      3'b001: begin pv = {32'h0, a} * {32'h0, b}; return pv; end
      3'b010: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb; qv = 64'(q); rv = 64'(r);
        return {rv[31:0], qv[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] exp_v);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    if (push) exp_q.push_back(exp_v);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic collect(input string name, input int exp_busy, input bit chk_pulse);
    int busy_cnt = 0;
    bit got = 0;
    logic [63:0] e;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: done not seen, busy_cnt=%0d", name, busy_cnt);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: done with empty queue", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (hi !== e[63:32]) begin
        errors++;
        $display("FAIL %s hi: got %h expected %h", name, hi, e[63:32]);
      end
      checks++;
      if (lo !== e[31:0]) begin
        errors++;
        $display("FAIL %s lo: got %h expected %h", name, lo, e[31:0]);
      end
      checks++;
      if (busy_cnt !== exp_busy) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
      end
      if (chk_pulse) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse: done still %b one cycle later", name, done);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 3'b0; rs_data = '0; rt_data = '0; flush = 1'b0;
    #12;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset lo: got %h expected 0", lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    issue(3'b000, 32'hFFFF_FFFD, 32'h7, 1, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    collect("mult_neg3x7", 33, 1);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, {32'hFFFF_FFFE, 32'h0000_0001});
    collect("multu_max", 33, 1);
  endtask

  task automatic test_div();
    issue(3'b010, 32'hFFFF_FFF9, 32'h2, 1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    collect("div_neg7by2", 33, 0);
    issue(3'b011, 32'h7, 32'h2, 1, {32'h1, 32'h3});
    collect("divu_7by2", 33, 0);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'h0, 32'h8000_0000});
    collect("div_overflow", 33, 0);
  endtask

  task automatic test_div0_mt();
    issue(3'b011, 32'h0000_1234, 32'h0, 1, {32'h0000_1234, 32'hFFFF_FFFF});
    collect("divu_by0", 33, 0);
    issue(3'b010, 32'hFFFF_FFFB, 32'h0, 1, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    collect("div_by0_signed", 33, 0);
    start = 1'b1; op = 3'b100; rs_data = 32'hA5A5_A5A5;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi hi: got %h expected a5a5a5a5", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mthi lo: got %h expected ffffffff", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi busy: got %b expected 0", busy); end
    start = 1'b1; op = 3'b101; rs_data = 32'h0BAD_F00D;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (lo !== 32'h0BAD_F00D) begin errors++; $display("FAIL mtlo lo: got %h expected 0badf00d", lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo done: got %b expected 0", done); end
    start = 1'b1; op = 3'b110; rs_data = 32'h1111_1111; rt_data = 32'h2;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL op110 busy: got %b expected 0", busy); end
    checks++; if ({hi, lo} !== {32'hA5A5_A5A5, 32'h0BAD_F00D})
      begin errors++; $display("FAIL op110 hilo: got %h_%h expected a5a5a5a5_0badf00d", hi, lo); end
  endtask

  task automatic test_start_busy_flush();
    logic [31:0] hi_prev, lo_prev;
    bit saw_done;
    issue(3'b000, 32'h6, 32'h7, 1, {32'h0, 32'd42});
    repeat (4) @(posedge clk);
    #1; start = 1'b1; op = 3'b001; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
    @(posedge clk); #1; start = 1'b0;
    collect("start_while_busy", 28, 0);
    hi_prev = hi; lo_prev = lo;
    issue(3'b010, 32'd100, 32'd7, 0, 64'h0);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b expected 0", busy); end
    checks++; if ({hi, lo} !== {hi_prev, lo_prev})
      begin errors++; $display("FAIL flush hilo: got %h_%h expected %h_%h", hi, lo, hi_prev, lo_prev); end
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL flush no_done: got done=1 expected none"); end
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = 3'b100; rs_data = 32'h5A5A_5A5A;
    @(posedge clk); #1; start = 1'b0;
    issue(3'b001, 32'hFFFF_FFFF, 32'h3, 0, 64'h0);
    repeat (5) @(posedge clk);
    #3;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset pre_busy: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL areset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL areset done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL areset hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL areset lo: got %h expected 0", lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(3'b011, 32'd9, 32'd3, 1, {32'h0, 32'h3});
    collect("divu_after_reset", 33, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    flush = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if (i == 1) a = 32'h8000_0000;
      if (i == 2) b = 32'hFFFF_FFFF;
      issue(o, a, b, 1, model(o, a, b));
      collect("back_to_back", 33, 0);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0_mt();
    test_start_busy_flush();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
